// File: rtl/axis_cmp_pkg.sv
// Shared types for the AXI4-Stream compare controller: FSM states and run status.
package axis_cmp_pkg;

    // Counts are held at a fixed maximum width; the controller masks them down to LEN_WIDTH.
    localparam int unsigned CMP_LEN_MAX = 64;

    typedef logic [CMP_LEN_MAX-1:0] cmp_len_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cmp_state_e;

    typedef struct packed {
        logic     pass;
        logic     timed_out;
        logic     aborted;
        cmp_len_t beat_count;
        cmp_len_t mismatch_count;
        cmp_len_t first_idx;
    } cmp_status_t;

    // A run passes only if it drained cleanly: no mismatch, no timeout, no abort.
    function automatic logic run_passed(input cmp_status_t s);
        return (s.mismatch_count == '0) && !s.timed_out && !s.aborted;
    endfunction

endpackage

// File: rtl/axis_cmp_watchdog.sv
// Stall watchdog: counts enabled cycles since the last clear and flags the TIMEOUT_CYCLES-th one.
module axis_cmp_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             at_last;

    assign at_last   = (count_q == LAST);
    // Expires during the last allowed stall cycle so the owner leaves on the following edge.
    assign expired_o = enable_i && !clear_i && at_last;

    // Next count: clear wins, otherwise advance on enabled cycles and hold at the limit.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !at_last) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/axis_compare_controller.sv
// Compares two AXI4-Stream inputs beat by beat over a run of programmable length.
module axis_compare_controller
    import axis_cmp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned LEN_WIDTH      = 32,  // at most CMP_LEN_MAX
    parameter int unsigned TIMEOUT_CYCLES = 1024 // at least 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic                  in1_valid,
    output logic                  in1_ready,
    input  logic [DATA_WIDTH-1:0] in2_data,
    input  logic                  in2_valid,
    output logic                  in2_ready,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timed_out,
    output logic                  aborted,
    output logic [LEN_WIDTH-1:0]  beat_count,
    output logic [LEN_WIDTH-1:0]  mismatch_count,
    output logic [LEN_WIDTH-1:0]  first_mismatch_idx
);

    localparam cmp_len_t LEN_MASK = (cmp_len_t'(1) << LEN_WIDTH) - cmp_len_t'(1);
    localparam cmp_status_t STATUS_CLEAR = '{
        pass:           1'b0,
        timed_out:      1'b0,
        aborted:        1'b0,
        beat_count:     '0,
        mismatch_count: '0,
        first_idx:      LEN_MASK
    };

    cmp_state_e           state_q, state_d;
    cmp_status_t          status_q, status_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    cmp_len_t             beats_next;
    logic                 run, beat;
    logic                 wd_clear, wd_enable, wd_expired;

    // Each ready mirrors the other stream's valid so a word moves only when both can; abort blocks the handshake.
    assign run       = (state_q == ST_RUN);
    assign in1_ready = run && !abort && in2_valid;
    assign in2_ready = run && !abort && in1_valid;
    assign beat      = run && !abort && in1_valid && in2_valid;

    assign wd_clear  = !run || beat;
    assign wd_enable = run && !beat;

    axis_cmp_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (wd_clear),
        .enable_i (wd_enable),
        .expired_o(wd_expired)
    );

    // Next-state and status update; priority within RUN is abort, then final beat, then timeout.
    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        len_d      = len_q;
        beats_next = (status_q.beat_count + cmp_len_t'(1)) & LEN_MASK;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d    = length;
                    status_d = STATUS_CLEAR;
                    if (length == '0) begin
                        status_d.pass = 1'b1;
                        state_d       = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    status_d.aborted = 1'b1;
                    state_d          = ST_DONE;
                end else if (beat) begin
                    status_d.beat_count = beats_next;
                    if (in1_data != in2_data) begin
                        status_d.mismatch_count = (status_q.mismatch_count + cmp_len_t'(1)) & LEN_MASK;
                        if (status_q.first_idx == LEN_MASK) begin
                            status_d.first_idx = status_q.beat_count;
                        end
                    end
                    if (beats_next == cmp_len_t'(len_q)) begin
                        state_d = ST_DONE;
                    end
                end else if (wd_expired) begin
                    status_d.timed_out = 1'b1;
                    state_d            = ST_DONE;
                end
                // Verdict is registered on entry to DONE so it is visible alongside the done pulse.
                if (state_d == ST_DONE) begin
                    status_d.pass = run_passed(status_d);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, status and length registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            status_q <= STATUS_CLEAR;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            len_q    <= len_d;
        end
    end

    assign busy               = run;
    assign done               = (state_q == ST_DONE);
    assign pass               = status_q.pass;
    assign timed_out          = status_q.timed_out;
    assign aborted            = status_q.aborted;
    assign beat_count         = status_q.beat_count[LEN_WIDTH-1:0];
    assign mismatch_count     = status_q.mismatch_count[LEN_WIDTH-1:0];
    assign first_mismatch_idx = status_q.first_idx[LEN_WIDTH-1:0];

endmodule

// File: tb/tb_axis_compare_controller.sv
// Directed self-checking bench for axis_compare_controller.
module tb_axis_compare_controller;

    logic        clk;
    logic        reset;
    logic [15:0] in1_data, in2_data;
    logic        in1_valid, in2_valid;
    logic        in1_ready, in2_ready;
    logic        start, abort;
    logic [7:0]  length;
    logic        busy, done, pass, timed_out, aborted;
    logic [7:0]  beat_count, mismatch_count, first_mismatch_idx;

    int tests = 0;
    int fails = 0;

    axis_compare_controller #(
        .DATA_WIDTH    (16),
        .LEN_WIDTH     (8),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in1_data          (in1_data),
        .in1_valid         (in1_valid),
        .in1_ready         (in1_ready),
        .in2_data          (in2_data),
        .in2_valid         (in2_valid),
        .in2_ready         (in2_ready),
        .start             (start),
        .length            (length),
        .abort             (abort),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .timed_out         (timed_out),
        .aborted           (aborted),
        .beat_count        (beat_count),
        .mismatch_count    (mismatch_count),
        .first_mismatch_idx(first_mismatch_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] a5[5];
        logic [15:0] b5[5];
        logic [15:0] a2[2];
        logic [15:0] b2[2];
        a5 = '{16'h1000, 16'h1001, 16'hBEEF, 16'h1003, 16'h1004};
        b5 = '{16'h1000, 16'h1001, 16'hDEAD, 16'h1003, 16'h1005};
        a2 = '{16'h0005, 16'h0006};
        b2 = '{16'h0005, 16'h0007};

        reset = 1'b1; start = 1'b0; abort = 1'b0; length = '0;
        in1_valid = 1'b0; in2_valid = 1'b0; in1_data = '0; in2_data = '0;
        repeat (2) cyc();
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst pass", pass, 0);
        check("rst timed_out", timed_out, 0);
        check("rst aborted", aborted, 0);
        check("rst beat_count", beat_count, 0);
        check("rst mismatch_count", mismatch_count, 0);
        check("rst first_idx", first_mismatch_idx, 32'hFF);
        check("rst in1_ready", in1_ready, 0);
        check("rst in2_ready", in2_ready, 0);
        reset = 1'b0;

        // Identical streams, length 4.
        cyc(); start = 1'b1; length = 8'd4; #1;
        check("A idle ready", in1_ready, 0);
        cyc(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in1_valid = 1'b1; in2_valid = 1'b1;
            in1_data = 16'(i + 1); in2_data = 16'(i + 1); #1;
            if (i == 0) begin
                check("A busy", busy, 1);
                check("A in1_ready", in1_ready, 1);
                check("A in2_ready", in2_ready, 1);
            end
            cyc();
        end
        in1_valid = 1'b0; in2_valid = 1'b0; #1;
        check("A done", done, 1);
        check("A pass", pass, 1);
        check("A beat_count", beat_count, 4);
        check("A mismatch_count", mismatch_count, 0);
        check("A first_idx", first_mismatch_idx, 32'hFF);
        check("A busy in done", busy, 0);
        cyc();
        check("A done pulse width", done, 0);
        check("A pass held", pass, 1);

        // Two mismatches at beats 2 and 4; start during DONE must be ignored.
        start = 1'b1; length = 8'd5;
        cyc(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in1_valid = 1'b1; in2_valid = 1'b1;
            in1_data = a5[i]; in2_data = b5[i]; #1;
            if (i == 3) begin
                check("B mid mismatch_count", mismatch_count, 1);
                check("B mid first_idx", first_mismatch_idx, 2);
                check("B mid beat_count", beat_count, 3);
            end
            cyc();
        end
        in1_valid = 1'b0; in2_valid = 1'b0; start = 1'b1; length = 8'd7; #1;
        check("B done", done, 1);
        check("B mismatch_count", mismatch_count, 2);
        check("B first_idx", first_mismatch_idx, 2);
        check("B beat_count", beat_count, 5);
        check("B pass", pass, 0);
        cyc(); start = 1'b0; #1;
        check("B start in DONE ignored", busy, 0);
        check("B beat_count held", beat_count, 5);

        // Timeout after one beat, in2 stalls.
        cyc(); start = 1'b1; length = 8'd3;
        cyc(); start = 1'b0;
        in1_valid = 1'b1; in2_valid = 1'b1; in1_data = 16'h0007; in2_data = 16'h0007;
        cyc();
        in2_valid = 1'b0; #1;
        check("C in1_ready follows in2_valid", in1_ready, 0);
        check("C in2_ready follows in1_valid", in2_ready, 1);
        check("C beat_count after beat", beat_count, 1);
        repeat (7) cyc();
        check("C still running at 8th stall", busy, 1);
        check("C no early timeout", timed_out, 0);
        cyc();
        check("C done", done, 1);
        check("C timed_out", timed_out, 1);
        check("C beat_count", beat_count, 1);
        check("C pass", pass, 0);
        check("C in2_ready dropped", in2_ready, 0);
        in1_valid = 1'b0;
        cyc();
        check("C timed_out held", timed_out, 1);
        check("C done cleared", done, 0);

        // Abort on the cycle of beat 3.
        start = 1'b1; length = 8'd4;
        cyc(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in1_valid = 1'b1; in2_valid = 1'b1;
            in1_data = 16'(i); in2_data = 16'(i);
            cyc();
        end
        in1_data = 16'h0002; in2_data = 16'h0002; abort = 1'b1; #1;
        check("D in1_ready masked by abort", in1_ready, 0);
        check("D in2_ready masked by abort", in2_ready, 0);
        cyc(); abort = 1'b0; in1_valid = 1'b0; in2_valid = 1'b0; #1;
        check("D done", done, 1);
        check("D aborted", aborted, 1);
        check("D pass", pass, 0);
        check("D beat_count", beat_count, 2);
        check("D timed_out", timed_out, 0);
        cyc();

        // Zero-length run.
        start = 1'b1; length = 8'd0; in1_valid = 1'b1; in2_valid = 1'b1; #1;
        check("E idle in1_ready", in1_ready, 0);
        cyc(); start = 1'b0; #1;
        check("E done", done, 1);
        check("E pass", pass, 1);
        check("E beat_count", beat_count, 0);
        check("E aborted cleared", aborted, 0);
        check("E in1_ready", in1_ready, 0);
        check("E in2_ready", in2_ready, 0);
        check("E busy", busy, 0);
        in1_valid = 1'b0; in2_valid = 1'b0;
        cyc(); abort = 1'b1;
        cyc(); abort = 1'b0; #1;
        check("E abort in IDLE ignored", aborted, 0);
        check("E pass held after idle abort", pass, 1);
        check("E idle after abort", busy, 0);

        // Reset mid-run, then a normal run.
        start = 1'b1; length = 8'd6;
        cyc(); start = 1'b0;
        in1_valid = 1'b1; in2_valid = 1'b1; in1_data = 16'h0009; in2_data = 16'h0009;
        cyc();
        #1 reset = 1'b1; #1;
        check("F rst busy", busy, 0);
        check("F rst beat_count", beat_count, 0);
        check("F rst first_idx", first_mismatch_idx, 32'hFF);
        check("F rst mismatch_count", mismatch_count, 0);
        check("F rst pass", pass, 0);
        check("F rst in1_ready", in1_ready, 0);
        check("F rst done", done, 0);
        in1_valid = 1'b0; in2_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            if (k == 0) reset = 1'b0;
            #1;
            check("F no done after reset", done, 0);
        end
        start = 1'b1; length = 8'd2;
        cyc(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in1_valid = 1'b1; in2_valid = 1'b1;
            in1_data = a2[i]; in2_data = b2[i];
            cyc();
        end
        in1_valid = 1'b0; in2_valid = 1'b0; #1;
        check("F done", done, 1);
        check("F beat_count", beat_count, 2);
        check("F mismatch_count", mismatch_count, 1);
        check("F first_idx", first_mismatch_idx, 1);
        check("F pass", pass, 0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
